// File: rtl/uart_tx_fifo_drain.sv
// ----------------------------------------------------------------------------
// uart_tx_fifo_drain
//
// UART transmitter acting as the read-side consumer of a first-word
// fall-through byte FIFO. Whenever the FIFO holds data and transmission is
// enabled, the head byte is popped and sent as an 8N1 frame on tx:
// start bit, 8 data bits LSB first, one stop bit.
//
// Ports:
//   clk         system clock, all logic on the rising edge
//   rst         synchronous reset, active-high
//   tx_en       1 = new frames may start; 0 = no new pops (current frame ends)
//   fifo_empty  FIFO empty flag
//   fifo_rdata  FIFO head byte, valid while fifo_empty = 0
//   fifo_rd     pop strobe to the FIFO, one clock per byte
//   tx          serial line, idle high, registered
//   tx_busy     high while a frame is in flight
//   tx_done     one-clock pulse on the last clock of the stop bit
// ----------------------------------------------------------------------------
module uart_tx_fifo_drain #(
    parameter int BAUD_DIV  = 868,
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_en,
    input  logic                 fifo_empty,
    input  logic [DATA_BITS-1:0] fifo_rdata,
    output logic                 fifo_rd,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t                state, state_next;
    logic [CNT_W-1:0]      baud_cnt, cnt_next;
    logic [IDX_W-1:0]      bit_idx, idx_next;
    logic [DATA_BITS-1:0]  shift_reg, shift_next;
    logic                  tx_next;
    logic                  baud_end;

    // Bit period ends on an explicit compare, so the counter never relies on
    // wrapping at a power of two.
    assign baud_end = (baud_cnt == BAUD_LAST);

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case statement can leave one unassigned (no latches).
        state_next = state;
        cnt_next   = baud_cnt;
        idx_next   = bit_idx;
        shift_next = shift_reg;
        tx_next    = tx;
        fifo_rd    = 1'b0;

        case (state)
            IDLE: begin
                tx_next = 1'b1;
                // Pop only from IDLE, and never while reset is applied.
                if (!rst && tx_en && !fifo_empty) begin
                    fifo_rd    = 1'b1;
                    shift_next = fifo_rdata;
                    tx_next    = 1'b0;
                    cnt_next   = '0;
                    state_next = START;
                end
            end
            START: begin
                if (baud_end) begin
                    cnt_next   = '0;
                    idx_next   = '0;
                    tx_next    = shift_reg[0];
                    state_next = DATA;
                end else begin
                    cnt_next = baud_cnt + 1'b1;
                end
            end
            DATA: begin
                if (baud_end) begin
                    cnt_next = '0;
                    if (bit_idx == IDX_LAST) begin
                        tx_next    = 1'b1;
                        state_next = STOP;
                    end else begin
                        // The next bit to send is shift_reg[1] before the shift.
                        shift_next = shift_reg >> 1;
                        idx_next   = bit_idx + 1'b1;
                        tx_next    = shift_reg[1];
                    end
                end else begin
                    cnt_next = baud_cnt + 1'b1;
                end
            end
            STOP: begin
                if (baud_end) begin
                    cnt_next   = '0;
                    state_next = IDLE;
                end else begin
                    cnt_next = baud_cnt + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (rst) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            tx        <= 1'b1;
        end else begin
            state     <= state_next;
            baud_cnt  <= cnt_next;
            bit_idx   <= idx_next;
            shift_reg <= shift_next;
            tx        <= tx_next;
        end
    end

    assign tx_busy = (state != IDLE);
    assign tx_done = (state == STOP) && baud_end;

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_fifo_drain
//
// Self-checking bench for uart_tx_fifo_drain with BAUD_DIV = 4. The bench
// plays the FIFO (a queue with first-word fall-through pins) and keeps a
// frame-level reference: after a pop, the line must show the 10-bit frame
// {stop, data, start} for BAUD clocks per bit, busy for the whole frame and
// done on its final clock.
// ----------------------------------------------------------------------------
module tb_uart_tx_fifo_drain;

    localparam int BAUD  = 4;
    localparam int FRAME = 10 * BAUD;

    logic       clk;
    logic       rst;
    logic       tx_en;
    logic       fifo_empty;
    logic [7:0] fifo_rdata;
    logic       fifo_rd;
    logic       tx;
    logic       tx_busy;
    logic       tx_done;

    uart_tx_fifo_drain #(.BAUD_DIV(BAUD), .DATA_BITS(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_en      (tx_en),
        .fifo_empty (fifo_empty),
        .fifo_rdata (fifo_rdata),
        .fifo_rd    (fifo_rd),
        .tx         (tx),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // FIFO model and reference state.
    logic [7:0] q[$];
    logic [7:0] sent[$];
    int         pop_cyc[$];
    int         done_cyc[$];
    int         busy_cycles;
    int         cyc = 0;
    int         pos = -1;       // clocks into the current frame, -1 = idle
    logic [9:0] frame_bits;
    logic       s_rd, s_tx, s_busy, s_done;

    task automatic update_pins();
        fifo_empty = (q.size() == 0);
        fifo_rdata = (q.size() != 0) ? q[0] : 8'($urandom);
    endtask

    task automatic push(input logic [7:0] b);
        q.push_back(b);
        update_pins();
    endtask

    task automatic clear_stats();
        sent.delete();
        pop_cyc.delete();
        done_cyc.delete();
        busy_cycles = 0;
    endtask

    // One clock: compare outputs at the falling edge, then apply the pop
    // just after the rising edge.
    task automatic cycle();
        logic exp_rd, exp_tx, exp_busy, exp_done;
        @(negedge clk);
        exp_rd   = !rst && pos < 0 && tx_en && q.size() != 0;
        exp_tx   = (pos < 0) ? 1'b1 : frame_bits[pos / BAUD];
        exp_busy = (pos >= 0);
        exp_done = (pos == FRAME - 1);
        s_rd = fifo_rd; s_tx = tx; s_busy = tx_busy; s_done = tx_done;

        checks += 4;
        if (s_rd !== exp_rd) begin
            errors++;
            $display("FAIL fifo_rd cyc=%0d got=%b exp=%b", cyc, s_rd, exp_rd);
        end
        if (s_tx !== exp_tx) begin
            errors++;
            $display("FAIL tx cyc=%0d pos=%0d got=%b exp=%b", cyc, pos, s_tx, exp_tx);
        end
        if (s_busy !== exp_busy) begin
            errors++;
            $display("FAIL tx_busy cyc=%0d got=%b exp=%b", cyc, s_busy, exp_busy);
        end
        if (s_done !== exp_done) begin
            errors++;
            $display("FAIL tx_done cyc=%0d got=%b exp=%b", cyc, s_done, exp_done);
        end

        if (s_rd === 1'b1)   pop_cyc.push_back(cyc);
        if (s_done === 1'b1) done_cyc.push_back(cyc);
        if (s_busy === 1'b1) busy_cycles++;

        if (rst)                 pos = -1;
        else if (pos >= 0)       pos = (pos == FRAME - 1) ? -1 : pos + 1;
        else if (exp_rd) begin
            pos        = 0;
            frame_bits = {1'b1, q[0], 1'b0};
        end

        @(posedge clk);
        #1;
        cyc++;
        if (s_rd === 1'b1 && q.size() != 0) sent.push_back(q.pop_front());
        update_pins();
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n = 0;
        do begin
            cycle();
            n++;
        end while (!(pos < 0 && (q.size() == 0 || !tx_en)) && n < budget);
        checks++;
        if (!(pos < 0 && (q.size() == 0 || !tx_en))) begin
            errors++;
            $display("FAIL %s timeout got=busy exp=idle within %0d clocks", tag, budget);
        end
    endtask

    task automatic run_to_pos(input int target, input string tag);
        int n = 0;
        while (pos != target && n < 4 * FRAME) begin
            cycle();
            n++;
        end
        checks++;
        if (pos != target) begin
            errors++;
            $display("FAIL %s reach_pos got=%0d exp=%0d", tag, pos, target);
        end
    endtask

    task automatic test_reset();
        clear_stats();
        tx_en = 1'b1;
        push(8'h5A);
        repeat (3) cycle();
        checks += 3;
        if (pop_cyc.size() !== 0) begin
            errors++; $display("FAIL reset_pop got=%0d exp=0", pop_cyc.size());
        end
        if (s_tx !== 1'b1) begin
            errors++; $display("FAIL reset_tx got=%b exp=1", s_tx);
        end
        if (s_busy !== 1'b0 || s_done !== 1'b0) begin
            errors++; $display("FAIL reset_flags got=%b%b exp=00", s_busy, s_done);
        end
        rst = 1'b0;
        wait_idle(3 * FRAME, "reset_release");
        checks++;
        if (sent.size() != 1 || sent[0] !== 8'h5A) begin
            errors++; $display("FAIL reset_release_byte got_n=%0d exp=5a", sent.size());
        end
    endtask

    task automatic test_single();
        clear_stats();
        push(8'hA5);
        wait_idle(3 * FRAME, "single");
        checks += 4;
        if (pop_cyc.size() != 1 || done_cyc.size() != 1) begin
            errors++;
            $display("FAIL single_pulses got=%0d/%0d exp=1/1", pop_cyc.size(), done_cyc.size());
        end else if (done_cyc[0] - pop_cyc[0] != FRAME) begin
            errors++;
            $display("FAIL single_done_delay got=%0d exp=%0d", done_cyc[0] - pop_cyc[0], FRAME);
        end
        if (busy_cycles != FRAME) begin
            errors++; $display("FAIL single_busy got=%0d exp=%0d", busy_cycles, FRAME);
        end
        if (sent.size() != 1 || sent[0] !== 8'hA5) begin
            errors++; $display("FAIL single_byte got_n=%0d exp=a5", sent.size());
        end
        if (fifo_empty !== 1'b1) begin
            errors++; $display("FAIL single_empty got=%b exp=1", fifo_empty);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_b[3] = '{8'h00, 8'hFF, 8'h55};
        clear_stats();
        foreach (exp_b[i]) push(exp_b[i]);
        wait_idle(5 * FRAME, "b2b");
        checks += 3;
        if (pop_cyc.size() != 3 || done_cyc.size() != 3) begin
            errors++;
            $display("FAIL b2b_pulses got=%0d/%0d exp=3/3", pop_cyc.size(), done_cyc.size());
        end else if (pop_cyc[1] - pop_cyc[0] != FRAME + 1 || pop_cyc[2] - pop_cyc[1] != FRAME + 1) begin
            errors++;
            $display("FAIL b2b_spacing got=%0d,%0d exp=%0d", pop_cyc[1] - pop_cyc[0],
                     pop_cyc[2] - pop_cyc[1], FRAME + 1);
        end
        if (sent.size() != 3) begin
            errors++; $display("FAIL b2b_count got=%0d exp=3", sent.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (sent[i] !== exp_b[i]) begin
                    errors++; $display("FAIL b2b_byte%0d got=%h exp=%h", i, sent[i], exp_b[i]);
                end
            end
        end
    endtask

    task automatic test_empty();
        clear_stats();
        repeat (100) cycle();
        checks++;
        if (pop_cyc.size() != 0 || busy_cycles != 0) begin
            errors++;
            $display("FAIL empty_idle got=pops%0d busy%0d exp=0/0", pop_cyc.size(), busy_cycles);
        end
    endtask

    task automatic test_enable_gating();
        int c0;
        clear_stats();
        tx_en = 1'b0;
        push(8'h3C);
        repeat (20) cycle();
        checks++;
        if (pop_cyc.size() != 0) begin
            errors++; $display("FAIL gate_nopop got=%0d exp=0", pop_cyc.size());
        end
        tx_en = 1'b1;
        c0 = cyc;
        cycle();
        checks++;
        if (pop_cyc.size() != 1 || pop_cyc[0] != c0) begin
            errors++; $display("FAIL gate_first_pop got_n=%0d exp=1 at %0d", pop_cyc.size(), c0);
        end
        push(8'h81);
        run_to_pos(3 * BAUD + 1, "gate_bit2");
        tx_en = 1'b0;
        wait_idle(3 * FRAME, "gate_finish");
        repeat (20) cycle();
        checks += 2;
        if (sent.size() != 1 || sent[0] !== 8'h3C) begin
            errors++; $display("FAIL gate_sent got_n=%0d exp=1 byte 3c", sent.size());
        end
        if (q.size() != 1 || fifo_empty !== 1'b0) begin
            errors++; $display("FAIL gate_held got=%0d/%b exp=1/0", q.size(), fifo_empty);
        end
        tx_en = 1'b1;
        wait_idle(3 * FRAME, "gate_drain");
    endtask

    task automatic test_reset_mid_frame();
        clear_stats();
        push(8'hF0);
        run_to_pos(4 * BAUD + 1, "rst_bit3");
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        cycle();
        checks += 2;
        if (s_tx !== 1'b1 || s_busy !== 1'b0) begin
            errors++; $display("FAIL rst_mid_line got=%b%b exp=10", s_tx, s_busy);
        end
        if (pop_cyc.size() != 1) begin
            errors++; $display("FAIL rst_mid_pops got=%0d exp=1", pop_cyc.size());
        end
        push(8'h11);
        wait_idle(3 * FRAME, "rst_next");
        checks++;
        if (sent.size() != 2 || sent[1] !== 8'h11) begin
            errors++; $display("FAIL rst_next_byte got_n=%0d exp=2 ending 11", sent.size());
        end
    endtask

    task automatic test_full_drain();
        clear_stats();
        for (int i = 1; i <= 8; i++) push(8'(i));
        wait_idle(10 * FRAME, "full");
        checks += 2;
        if (pop_cyc.size() != 8 || fifo_empty !== 1'b1) begin
            errors++; $display("FAIL full_pops got=%0d/%b exp=8/1", pop_cyc.size(), fifo_empty);
        end
        repeat (5) cycle();
        if (s_tx !== 1'b1) begin
            errors++; $display("FAIL full_idle_line got=%b exp=1", s_tx);
        end
        for (int i = 0; i < 8 && i < sent.size(); i++) begin
            checks++;
            if (sent[i] !== 8'(i + 1)) begin
                errors++; $display("FAIL full_byte%0d got=%h exp=%h", i, sent[i], i + 1);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] pushed[$];
        logic [7:0] b;
        clear_stats();
        for (int n = 0; n < 1500; n++) begin
            if (pushed.size() < 16 && q.size() < 8 && $urandom_range(0, 29) == 0) begin
                b = 8'($urandom);
                pushed.push_back(b);
                push(b);
            end
            if ($urandom_range(0, 99) == 0) tx_en = ~tx_en;
            cycle();
        end
        tx_en = 1'b1;
        wait_idle(10 * FRAME, "random");
        checks++;
        if (sent.size() != pushed.size()) begin
            errors++; $display("FAIL rand_count got=%0d exp=%0d", sent.size(), pushed.size());
        end
        for (int i = 0; i < sent.size() && i < pushed.size(); i++) begin
            checks++;
            if (sent[i] !== pushed[i]) begin
                errors++; $display("FAIL rand_byte%0d got=%h exp=%h", i, sent[i], pushed[i]);
            end
        end
    endtask

    initial begin
        rst   = 1'b1;
        tx_en = 1'b0;
        update_pins();
        @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_back_to_back();
        test_empty();
        test_enable_gating();
        test_reset_mid_frame();
        test_full_drain();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
